dot_product_mac: RTL and testbench
==================================

DOT_PRODUCT_MAC -- requirements
Module: dot_product_mac

Interface
REQ-001 The block SHALL have parameter K, default 4: number of element pairs per dot product, legal range 1..16.
REQ-002 The block SHALL have parameter ACC_W, default 12: accumulator and result width, legal range 8..16.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an operand pair is offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts an operand pair this cycle.
REQ-007 The block SHALL have port a, input, 4 bits: unsigned matrix-row element.
REQ-008 The block SHALL have port b, input, 4 bits: unsigned matrix-column element.
REQ-009 The block SHALL have port out_valid, output, 1 bit: result holds a completed dot product.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 The block SHALL have port result, output, ACC_W bits: the dot-product value.
REQ-012 The block SHALL have port ovf, output, 1 bit: sticky overflow flag for the current dot product.

Function
REQ-013 The FSM SHALL have four states: IDLE, MUL, ACC, OUT.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in OUT.
REQ-015 Handshake in IDLE (in_valid && in_ready): the block SHALL capture a and b, clear the 8-bit product register and the bit index, and go to MUL.
REQ-016 MUL SHALL last exactly 4 cycles; in cycle i (0..3) the block SHALL add (a << i) to the product when b[i]=1, then go to ACC.
REQ-017 ACC SHALL last 1 cycle: acc <= acc + product zero-extended to ACC_W, term_cnt <= term_cnt + 1.
REQ-018 After ACC, the block SHALL go to OUT when the term just added was term K, otherwise to IDLE.
REQ-019 Per-element throughput SHALL be 6 cycles: handshake at cycle t puts in_ready or out_valid high at t+6.
REQ-020 result SHALL equal acc and SHALL be stable while out_valid=1 and out_ready=0.
REQ-021 OUT with out_ready=1 SHALL clear acc, term_cnt and ovf and go to IDLE, so in_ready=1 on the next cycle; no input is accepted in that same cycle.
REQ-022 in_valid while not in IDLE SHALL be ignored, and a/b changes outside the handshake cycle SHALL NOT affect the result.
REQ-023 With K=1, every accepted pair SHALL produce one result.

Reset
REQ-024 When rst=1 at a clock edge, the block SHALL enter IDLE with acc=0, term_cnt=0, product=0 and ovf=0, giving in_ready=1, out_valid=0, result=0 and ovf=0 on the next cycle.
REQ-025 Reset in MUL, ACC or OUT SHALL discard the partial or held dot product entirely.
REQ-026 Reset SHALL take priority over any handshake in the same cycle.

Configuration
REQ-027 The configuration macro SHALL be ACC_SAT_EN.
REQ-028 With ACC_SAT_EN defined: if the ACC sum exceeds 2^ACC_W-1, acc SHALL saturate to all-ones and ovf SHALL set and remain set until the result is consumed or rst is asserted; further additions SHALL keep acc at all-ones.
REQ-029 With ACC_SAT_EN undefined: acc SHALL wrap modulo 2^ACC_W and ovf SHALL be constant 0.

Structure
REQ-030 Package dp_mac_pkg SHALL hold the state enum (IDLE/MUL/ACC/OUT), ELEM_W=4, PROD_W=8 and MUL_STEPS=4.
REQ-031 The design SHALL have one sub-module, mul4_seq: a 4-cycle shift-add multiplier with start/done and an 8-bit product; the FSM, counter and accumulator SHALL stay in the top module.

Verification
REQ-032 The bench SHALL cover default parameters with four pairs (15,15), out_ready=1: out_valid=1 six cycles after the 4th handshake, result=900 (0x384), ovf=0.
REQ-033 The bench SHALL cover pairs (3,5),(2,7),(0,9),(1,1) with out_ready=0 for 10 cycles: result=30 held stable, in_ready=0 throughout, then in_ready=1 on the cycle after out_ready=1.
REQ-034 The bench SHALL cover ACC_W=8, K=4, four pairs (15,15): with ACC_SAT_EN, result=255 and ovf=1; without it, result=900 mod 256=132 and ovf=0.
REQ-035 The bench SHALL cover rst pulsed during MUL of the 2nd pair, then four pairs (1,2): result=8, so no residue from the aborted sum.
REQ-036 The bench SHALL cover K=1 with back-to-back in_valid=1 on pairs (4,4) and (2,3): results 16 then 6, one handshake per 6 cycles plus OUT.

Source files
------------

// File: rtl/dp_mac_pkg.sv
// Shared types and constants for the dot-product MAC: FSM state encoding
// and operand/product widths used by the top and the shift-add multiplier.
package dp_mac_pkg;

  localparam int ELEM_W    = 4;
  localparam int PROD_W    = 8;
  localparam int MUL_STEPS = 4;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    ACC,
    OUT
  } state_e;

endpackage

// File: rtl/dot_product_mac_mul4_seq.sv
// 4-cycle shift-add multiplier: start captures the operands and clears the
// product; one multiplier bit is consumed per cycle, done marks the last step.
module mul4_seq
  import dp_mac_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ELEM_W-1:0] a_i,
  input  logic [ELEM_W-1:0] b_i,
  output logic [PROD_W-1:0] product_o,
  output logic              done_o
);

  localparam int IDX_W = $clog2(MUL_STEPS);

  logic [ELEM_W-1:0] a_q;
  logic [ELEM_W-1:0] b_q;
  logic [PROD_W-1:0] prod_q;
  logic [PROD_W-1:0] prod_d;
  logic [IDX_W-1:0]  idx_q;
  logic              busy_q;
  logic              last_step;

  assign last_step = (idx_q == IDX_W'(MUL_STEPS - 1));

  always_comb begin
    prod_d = prod_q;
    if (b_q[idx_q]) begin
      prod_d = prod_q + (PROD_W'(a_q) << idx_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      prod_q <= '0;
      idx_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      a_q    <= a_i;
      b_q    <= b_i;
      prod_q <= '0;
      idx_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      prod_q <= prod_d;
      idx_q  <= idx_q + IDX_W'(1);
      if (last_step) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign product_o = prod_q;
  assign done_o    = busy_q && last_step;

endmodule

// File: rtl/dot_product_mac.sv
// Sequential dot-product MAC: one 4-bit operand pair per 6 cycles, K terms
// per result. Define ACC_SAT_EN for a saturating accumulator with sticky ovf.
module dot_product_mac
  import dp_mac_pkg::*;
#(
  parameter int K     = 4,
  parameter int ACC_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  result,
  output logic              ovf
);

  localparam int CNT_W = $clog2(K + 1);
  localparam int SUM_W = ACC_W + 1;

  state_e            state_q;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  acc_d;
  logic [CNT_W-1:0]  term_cnt_q;
  logic [CNT_W-1:0]  term_cnt_d;
  logic              ovf_q;
  logic              ovf_d;
  logic [SUM_W-1:0]  sum;
  logic              last_term;

  logic              mul_start;
  logic              mul_done;
  logic [PROD_W-1:0] mul_product;

  assign mul_start = (state_q == IDLE) && in_valid;

  mul4_seq u_mul (
    .clk       (clk),
    .rst       (rst),
    .start_i   (mul_start),
    .a_i       (a),
    .b_i       (b),
    .product_o (mul_product),
    .done_o    (mul_done)
  );

  assign sum        = {1'b0, acc_q} + SUM_W'(mul_product);
  assign term_cnt_d = term_cnt_q + CNT_W'(1);
  assign last_term  = (term_cnt_q == CNT_W'(K - 1));

`ifdef ACC_SAT_EN
  // Once saturated, stay pinned at all-ones until the result is consumed.
  always_comb begin
    acc_d = sum[ACC_W-1:0];
    ovf_d = ovf_q;
    if (ovf_q || sum[ACC_W]) begin
      acc_d = '1;
      ovf_d = 1'b1;
    end
  end
`else
  always_comb begin
    acc_d = sum[ACC_W-1:0];
    ovf_d = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      term_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q <= MUL;
          end
        end
        MUL: begin
          if (mul_done) begin
            state_q <= ACC;
          end
        end
        ACC: begin
          acc_q      <= acc_d;
          ovf_q      <= ovf_d;
          term_cnt_q <= term_cnt_d;
          state_q    <= last_term ? OUT : IDLE;
        end
        OUT: begin
          if (out_ready) begin
            acc_q      <= '0;
            term_cnt_q <= '0;
            ovf_q      <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign result    = acc_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_dot_product_mac.sv
// Scoreboard bench for dot_product_mac: three instances (default, ACC_W=8,
// K=1); expected values follow ACC_SAT_EN when it is defined.
module tb_dot_product_mac;

  typedef struct {
    int   res;
    logic ovf;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [2:0] inValid;
  logic [2:0] inReady;
  logic [2:0] outValid;
  logic [2:0] outReady;
  logic [2:0] ovfO;
  logic [3:0] aIn [3];
  logic [3:0] bIn [3];
  logic [11:0] res0;
  logic [7:0]  res1;
  logic [11:0] res2;

  exp_t expQ0[$];
  exp_t expQ1[$];
  exp_t expQ2[$];

  int checks = 0;
  int errors = 0;

  dot_product_mac #(.K(4), .ACC_W(12)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(inValid[0]), .in_ready(inReady[0]),
    .a(aIn[0]), .b(bIn[0]), .out_valid(outValid[0]), .out_ready(outReady[0]),
    .result(res0), .ovf(ovfO[0])
  );

  dot_product_mac #(.K(4), .ACC_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(inValid[1]), .in_ready(inReady[1]),
    .a(aIn[1]), .b(bIn[1]), .out_valid(outValid[1]), .out_ready(outReady[1]),
    .result(res1), .ovf(ovfO[1])
  );

  dot_product_mac #(.K(1), .ACC_W(12)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(inValid[2]), .in_ready(inReady[2]),
    .a(aIn[2]), .b(bIn[2]), .out_valid(outValid[2]), .out_ready(outReady[2]),
    .result(res2), .ovf(ovfO[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int resOf(input int d);
    case (d)
      0:       return int'(res0);
      1:       return int'(res1);
      default: return int'(res2);
    endcase
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Offer one pair, wait for the handshake, scramble a/b afterwards and
  // verify the 6-cycle spacing to the next in_ready/out_valid.
  task automatic applyStimulus(input int d, input logic [3:0] av, input logic [3:0] bv);
    int waitCnt = 0;
    @(negedge clk);
    aIn[d] = av;
    bIn[d] = bv;
    inValid[d] = 1'b1;
    while (!inReady[d] && waitCnt < 40) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("in_ready_wait", int'(inReady[d]), 1);
    @(posedge clk);
    #1;
    inValid[d] = 1'b0;
    aIn[d] = ~av;
    bIn[d] = bv ^ 4'hA;
    repeat (5) @(negedge clk);
    checkOutput("busy_at_t5", int'({inReady[d], outValid[d]}), 0);
    @(negedge clk);
    checkOutput("ready_at_t6", int'(inReady[d] | outValid[d]), 1);
  endtask

  // Monitor: pop and compare whenever a result is taken.
  always @(negedge clk) begin
    exp_t e;
    if (outValid[0] && outReady[0]) begin
      if (expQ0.size() == 0) checkOutput("dut0_unexpected", 1, 0);
      else begin
        e = expQ0.pop_front();
        checkOutput("dut0_result", resOf(0), e.res);
        checkOutput("dut0_ovf", int'(ovfO[0]), int'(e.ovf));
      end
    end
    if (outValid[1] && outReady[1]) begin
      if (expQ1.size() == 0) checkOutput("dut1_unexpected", 1, 0);
      else begin
        e = expQ1.pop_front();
        checkOutput("dut1_result", resOf(1), e.res);
        checkOutput("dut1_ovf", int'(ovfO[1]), int'(e.ovf));
      end
    end
    if (outValid[2] && outReady[2]) begin
      if (expQ2.size() == 0) checkOutput("dut2_unexpected", 1, 0);
      else begin
        e = expQ2.pop_front();
        checkOutput("dut2_result", resOf(2), e.res);
        checkOutput("dut2_ovf", int'(ovfO[2]), int'(e.ovf));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    inValid = 3'b111;
    outReady = 3'b111;
    for (int i = 0; i < 3; i++) begin
      aIn[i] = 4'hF;
      bIn[i] = 4'hF;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    inValid = 3'b000;

    // Reset state on all instances (in_valid was high during reset).
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checkOutput("rst_in_ready", int'(inReady[d]), 1);
      checkOutput("rst_out_valid", int'(outValid[d]), 0);
      checkOutput("rst_result", resOf(d), 0);
      checkOutput("rst_ovf", int'(ovfO[d]), 0);
    end

    // Four (15,15) pairs, consumer always ready: 4*225 = 900.
    expQ0.push_back('{900, 1'b0});
    for (int i = 0; i < 4; i++) applyStimulus(0, 4'd15, 4'd15);

    // Back-pressure: 15+14+0+1 = 30 held for 10 cycles.
    @(posedge clk);
    #1;
    outReady[0] = 1'b0;
    expQ0.push_back('{30, 1'b0});
    applyStimulus(0, 4'd3, 4'd5);
    applyStimulus(0, 4'd2, 4'd7);
    applyStimulus(0, 4'd0, 4'd9);
    applyStimulus(0, 4'd1, 4'd1);
    inValid[0] = 1'b1;
    aIn[0] = 4'd9;
    bIn[0] = 4'd9;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("hold_out_valid", int'(outValid[0]), 1);
      checkOutput("hold_in_ready", int'(inReady[0]), 0);
      checkOutput("hold_result", resOf(0), 30);
    end
    @(posedge clk);
    #1;
    inValid[0] = 1'b0;
    outReady[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("release_in_ready", int'(inReady[0]), 1);
    checkOutput("release_result", resOf(0), 0);

    // Reset during MUL of the second pair discards the partial sum.
    applyStimulus(0, 4'd5, 4'd5);
    @(negedge clk);
    aIn[0] = 4'd7;
    bIn[0] = 4'd7;
    inValid[0] = 1'b1;
    @(posedge clk);
    #1;
    inValid[0] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_in_ready", int'(inReady[0]), 1);
    checkOutput("midrst_out_valid", int'(outValid[0]), 0);
    checkOutput("midrst_result", resOf(0), 0);
    expQ0.push_back('{8, 1'b0});
    for (int i = 0; i < 4; i++) applyStimulus(0, 4'd1, 4'd2);

    // Narrow accumulator: 900 overflows 8 bits.
`ifdef ACC_SAT_EN
    expQ1.push_back('{255, 1'b1});
`else
    expQ1.push_back('{132, 1'b0});
`endif
    for (int i = 0; i < 4; i++) applyStimulus(1, 4'd15, 4'd15);

    // K=1, in_valid held high: 16 then 6, second handshake right after OUT.
    expQ2.push_back('{16, 1'b0});
    expQ2.push_back('{6, 1'b0});
    @(negedge clk);
    aIn[2] = 4'd4;
    bIn[2] = 4'd4;
    inValid[2] = 1'b1;
    checkOutput("k1_in_ready0", int'(inReady[2]), 1);
    @(posedge clk);
    #1;
    aIn[2] = 4'd2;
    bIn[2] = 4'd3;
    repeat (5) @(negedge clk);
    checkOutput("k1_busy", int'({inReady[2], outValid[2]}), 0);
    @(negedge clk);
    checkOutput("k1_out_valid0", int'(outValid[2]), 1);
    @(negedge clk);
    checkOutput("k1_in_ready1", int'(inReady[2]), 1);
    @(posedge clk);
    #1;
    inValid[2] = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("k1_out_valid1", int'(outValid[2]), 1);

    repeat (3) @(negedge clk);
    checkOutput("sb0_drained", expQ0.size(), 0);
    checkOutput("sb1_drained", expQ1.size(), 0);
    checkOutput("sb2_drained", expQ2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
